// File: rtl/ps_sobel.sv
// ----------------------------------------------------------------------------
// ps_sobel -- streaming 3x3 Sobel edge-detection stage (RGB444 in, RGB444 out)
//
// Each accepted pixel is converted to 4-bit luma and pushed through two line
// buffers and a 3x3 window. The window centre is at (row-1, col-1) of the
// accepted pixel. The gradient magnitude is emitted as a grey pixel. Pixels
// with row < 2 or col < 2 are forced to black, so stale window or line-buffer
// data never reaches the output. With i_mode = 0 the input pixel is passed
// through with the same latency. Every accepted input yields exactly one output,
// in order, three cycles after the cycle in which i_valid was presented.
//
// Build option:
//   SOBEL_THRESH_EN  when defined, Sobel-mode pixels become binary
//                    (mag >= THRESH -> 12'hFFF, else 12'h000).
//
// Ports:
//   i_clk    processing clock
//   i_rstn   synchronous active-low reset (counters, valid bits, outputs)
//   i_mode   0 = passthrough, 1 = Sobel; captured with each i_valid
//   i_valid  input pixel strobe (no backpressure)
//   i_data   input pixel {R[3:0], G[3:0], B[3:0]}
//   o_valid  output pixel strobe
//   o_data   output pixel
// ----------------------------------------------------------------------------
module ps_sobel #(
    parameter int         IMG_WIDTH  = 640,
    parameter int         IMG_HEIGHT = 480,
    parameter logic [6:0] THRESH     = 7'd32
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic        i_mode,
    input  logic        i_valid,
    input  logic [11:0] i_data,
    output logic        o_valid,
    output logic [11:0] o_data
);

    localparam int COL_W = $clog2(IMG_WIDTH);
    localparam int ROW_W = $clog2(IMG_HEIGHT);

    // 1*a + 2*b + 1*c on 4-bit samples; at most 60, so 6 bits are enough.
    function automatic logic [5:0] wsum(input logic [3:0] a, input logic [3:0] b,
                                        input logic [3:0] c);
        return {2'b00, a} + {1'b0, b, 1'b0} + {2'b00, c};
    endfunction

    // ------------------------------------------------------------------
    // Position counters
    // ------------------------------------------------------------------
    logic [COL_W-1:0] col_reg;
    logic [ROW_W-1:0] row_reg;

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            col_reg <= '0;
            row_reg <= '0;
        end else if (i_valid) begin
            if (col_reg == COL_W'(IMG_WIDTH - 1)) begin
                col_reg <= '0;
                if (row_reg == ROW_W'(IMG_HEIGHT - 1))
                    row_reg <= '0;
                else
                    row_reg <= row_reg + ROW_W'(1);
            end else begin
                col_reg <= col_reg + COL_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // S1: luma, line-buffer read, border flag, mode capture
    // ------------------------------------------------------------------
    logic [3:0] y_in;
    assign y_in = 4'(({2'b00, i_data[11:8]} + {1'b0, i_data[7:4], 1'b0}
                      + {2'b00, i_data[3:0]}) >> 2);

    // Both line buffers share one memory word per column:
    // [7:4] = luma of row r-1, [3:0] = luma of row r-2.
    logic [7:0]       lb_mem [0:IMG_WIDTH-1];
    logic [7:0]       lb_rd_reg;
    logic             s1_valid_reg;
    logic             s1_mode_reg;
    logic             s1_border_reg;
    logic [11:0]      s1_data_reg;
    logic [3:0]       s1_y_reg;
    logic [COL_W-1:0] s1_col_reg;

    // Registered read of the column now arriving. The write-back of the
    // previous pixel's column happens one cycle later at its own (registered)
    // address, which always differs from the column being read, so the
    // memory behaves as a simple dual-port RAM without a read/write clash.
    always_ff @(posedge i_clk) begin
        if (i_valid)
            lb_rd_reg <= lb_mem[col_reg];
        if (s1_valid_reg)
            lb_mem[s1_col_reg] <= {s1_y_reg, lb_rd_reg[7:4]};
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn)
            s1_valid_reg <= 1'b0;
        else
            s1_valid_reg <= i_valid;
    end

    always_ff @(posedge i_clk) begin
        if (i_valid) begin
            s1_mode_reg   <= i_mode;
            s1_border_reg <= (row_reg < ROW_W'(2)) || (col_reg < COL_W'(2));
            s1_data_reg   <= i_data;
            s1_y_reg      <= y_in;
            s1_col_reg    <= col_reg;
        end
    end

    // ------------------------------------------------------------------
    // S2: window shift and gradients
    // ------------------------------------------------------------------
    // win_reg[r][c]: r = 0 is row r-2 (top), c = 0 is column c-2 (left).
    logic [3:0] win_reg  [0:2][0:2];
    logic [3:0] win_next [0:2][0:2];
    logic [3:0] new_col  [0:2];

    assign new_col[0] = lb_rd_reg[3:0];
    assign new_col[1] = lb_rd_reg[7:4];
    assign new_col[2] = s1_y_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_win_shift
            assign win_next[gi][0] = win_reg[gi][1];
            assign win_next[gi][1] = win_reg[gi][2];
            assign win_next[gi][2] = new_col[gi];
        end
    endgenerate

    // Gradients are taken on the shifted window so they are ready in the
    // same stage that the window advances.
    logic [5:0] gx_pos, gx_neg, gy_pos, gy_neg;
    logic [6:0] gx_next, gy_next;

    assign gx_pos  = wsum(win_next[0][2], win_next[1][2], win_next[2][2]);
    assign gx_neg  = wsum(win_next[0][0], win_next[1][0], win_next[2][0]);
    assign gy_pos  = wsum(win_next[2][0], win_next[2][1], win_next[2][2]);
    assign gy_neg  = wsum(win_next[0][0], win_next[0][1], win_next[0][2]);
    assign gx_next = {1'b0, gx_pos} - {1'b0, gx_neg};
    assign gy_next = {1'b0, gy_pos} - {1'b0, gy_neg};

    logic        s2_valid_reg;
    logic        s2_mode_reg;
    logic        s2_border_reg;
    logic [11:0] s2_data_reg;
    logic [6:0]  s2_gx_reg;
    logic [6:0]  s2_gy_reg;

    always_ff @(posedge i_clk) begin
        if (s1_valid_reg) begin
            win_reg       <= win_next;
            s2_mode_reg   <= s1_mode_reg;
            s2_border_reg <= s1_border_reg;
            s2_data_reg   <= s1_data_reg;
            s2_gx_reg     <= gx_next;
            s2_gy_reg     <= gy_next;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn)
            s2_valid_reg <= 1'b0;
        else
            s2_valid_reg <= s1_valid_reg;
    end

    // ------------------------------------------------------------------
    // S3: magnitude, scaling, output mux
    // ------------------------------------------------------------------
    logic [6:0]  abs_gx, abs_gy, mag;
    logic [11:0] sobel_px;
    logic [11:0] out_px;

    // Gradients are two's complement in 7 bits; |g| never exceeds 60.
    assign abs_gx = s2_gx_reg[6] ? (7'd0 - s2_gx_reg) : s2_gx_reg;
    assign abs_gy = s2_gy_reg[6] ? (7'd0 - s2_gy_reg) : s2_gy_reg;
    assign mag    = abs_gx + abs_gy;

`ifdef SOBEL_THRESH_EN
    assign sobel_px = (mag >= THRESH) ? 12'hFFF : 12'h000;
`else
    logic [3:0] mag_scaled;
    logic       unused_thresh;
    assign mag_scaled    = 4'(mag >> 3);
    assign sobel_px      = {mag_scaled, mag_scaled, mag_scaled};
    assign unused_thresh = ^THRESH;
`endif

    always_comb begin
        out_px = s2_data_reg;
        if (s2_mode_reg)
            out_px = s2_border_reg ? 12'h000 : sobel_px;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            o_valid <= 1'b0;
            o_data  <= 12'h000;
        end else begin
            o_valid <= s2_valid_reg;
            if (s2_valid_reg)
                o_data <= out_px;
        end
    end

endmodule

// File: tb/tb_ps_sobel.sv
// ----------------------------------------------------------------------------
// tb_ps_sobel -- self-checking bench for ps_sobel on a small 16x8 frame.
// A frame-level model keeps the luma of every pixel of the current frame and
// derives each expected output directly from the 3x3 neighbourhood, together
// with the cycle on which it must appear. A compare process checks o_valid /
// o_data on every cycle against that expectation queue.
// ----------------------------------------------------------------------------
module tb_ps_sobel;

    localparam int         W  = 16;
    localparam int         H  = 8;
    localparam logic [6:0] TH = 7'd32;

`ifdef SOBEL_THRESH_EN
    localparam logic [11:0] EDGE    = 12'hFFF;
    localparam logic [11:0] CORNER  = 12'h000;
`else
    localparam logic [11:0] EDGE    = 12'h777;
    localparam logic [11:0] CORNER  = 12'h333;
`endif

    logic        clk  = 1'b0;
    logic        rstn = 1'b0;
    logic        mode = 1'b0;
    logic        valid = 1'b0;
    logic [11:0] data = 12'h000;
    logic        ov;
    logic [11:0] od;

    ps_sobel #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .THRESH(TH)) dut (
        .i_clk  (clk),
        .i_rstn (rstn),
        .i_mode (mode),
        .i_valid(valid),
        .i_data (data),
        .o_valid(ov),
        .o_data (od)
    );

    always #4 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int          t;
        logic [11:0] v;
    } exp_t;

    exp_t q[$];
    int   ymem [H][W];
    int   mr = 0;
    int   mc = 0;

    function automatic int luma(input logic [11:0] d);
        return (int'(d[11:8]) + 2 * int'(d[7:4]) + int'(d[3:0])) / 4;
    endfunction

    function automatic int px_at(input logic [35:0] w, input int r, input int c);
        return int'(w[(r * 3 + c) * 4 +: 4]);
    endfunction

    // w holds a 3x3 luma neighbourhood, nibble (r*3+c), r = 0 top, c = 0 left.
    function automatic logic [11:0] sobel_of(input logic [35:0] w);
        int gx, gy, mag;
        gx = (px_at(w, 0, 2) + 2 * px_at(w, 1, 2) + px_at(w, 2, 2))
           - (px_at(w, 0, 0) + 2 * px_at(w, 1, 0) + px_at(w, 2, 0));
        gy = (px_at(w, 2, 0) + 2 * px_at(w, 2, 1) + px_at(w, 2, 2))
           - (px_at(w, 0, 0) + 2 * px_at(w, 0, 1) + px_at(w, 0, 2));
        mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
`ifdef SOBEL_THRESH_EN
        return (mag >= int'(TH)) ? 12'hFFF : 12'h000;
`else
        return 12'((mag / 8) * 12'h111);
`endif
    endfunction

    // Drive one pixel (called just after a rising edge) and record its
    // expected output, due 3 cycles after the cycle it is presented in.
    task automatic px(input logic [11:0] d, input logic m, input int gap);
        logic [11:0] e;
        logic [35:0] w;
        valid = 1'b1;
        data  = d;
        mode  = m;
        ymem[mr][mc] = luma(d);
        if (!m)
            e = d;
        else if (mr < 2 || mc < 2)
            e = 12'h000;
        else begin
            w = '0;
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    w[(r * 3 + c) * 4 +: 4] = 4'(ymem[mr - 2 + r][mc - 2 + c]);
            e = sobel_of(w);
        end
        q.push_back('{cyc + 3, e});
        if (mc == W - 1) begin
            mc = 0;
            mr = (mr == H - 1) ? 0 : mr + 1;
        end else begin
            mc = mc + 1;
        end
        @(posedge clk); #1;
        valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    function automatic logic [11:0] edge_pix(input int i);
        return ((i % W) < W / 2) ? 12'h000 : 12'hFFF;
    endfunction

    // ---------------- compare process ----------------
    logic mon_en     = 1'b0;
    logic edge_phase = 1'b0;
    int   edge_cnt   = 0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (q.size() > 0 && q[0].t < cyc) begin
                chk("missed_output_slot", 12'h000, 12'h001);
                void'(q.pop_front());
            end
            if (q.size() > 0 && q[0].t == cyc) begin
                chk("o_valid_due", {11'b0, ov}, 12'h001);
                chk("o_data", od, q[0].v);
                if (edge_phase && ov && od == EDGE) edge_cnt++;
                void'(q.pop_front());
            end else begin
                chk("o_valid_idle", {11'b0, ov}, 12'h000);
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [35:0] wpin;
    int          npx;

    initial begin
        // Model pins: hand-computed Sobel responses.
        wpin = {9{4'h8}};
        chk("pin_flat", sobel_of(wpin), 12'h000);
        wpin = '0;
        for (int r = 0; r < 3; r++) wpin[(r * 3 + 2) * 4 +: 4] = 4'hF;
        chk("pin_vedge", sobel_of(wpin), EDGE);
        wpin = '0;
        for (int c = 0; c < 3; c++) wpin[(6 + c) * 4 +: 4] = 4'hF;
        chk("pin_hedge", sobel_of(wpin), EDGE);
        wpin = '0;
        wpin[8 * 4 +: 4] = 4'hF;
        chk("pin_corner", sobel_of(wpin), CORNER);
        chk("pin_luma", 12'(luma(12'hFFF)), 12'h00F);

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("reset_o_valid", {11'b0, ov}, 12'h000);
        chk("reset_o_data", od, 12'h000);
        rstn   = 1'b1;
        mon_en = 1'b1;
        idle(2);

        // Flat field.
        for (int i = 0; i < W * H; i++) px(12'h888, 1'b1, 0);
        idle(6);

        // Vertical edge, continuous.
        edge_cnt = 0; edge_phase = 1'b1;
        for (int i = 0; i < W * H; i++) px(edge_pix(i), 1'b1, 0);
        idle(6);
        edge_phase = 1'b0;
        chk("edge_count_cont", 12'(edge_cnt), 12'(2 * (H - 2)));

        // Passthrough ramp.
        for (int i = 0; i < W * H; i++) px(12'(i), 1'b0, 0);
        idle(6);

        // Vertical edge, every other cycle.
        edge_cnt = 0; edge_phase = 1'b1;
        for (int i = 0; i < W * H; i++) px(edge_pix(i), 1'b1, 1);
        idle(6);
        edge_phase = 1'b0;
        chk("edge_count_gapped", 12'(edge_cnt), 12'(2 * (H - 2)));

        // Reset mid-frame with a simultaneous pixel, then a full edge frame.
        for (int i = 0; i < 5 * W + 3; i++) px(edge_pix(i), 1'b1, 0);
        rstn  = 1'b0;
        valid = 1'b1;
        data  = 12'hABC;
        mode  = 1'b1;
        @(posedge clk); #1;
        valid = 1'b0;
        q.delete();
        mr = 0;
        mc = 0;
        chk("midreset_o_valid", {11'b0, ov}, 12'h000);
        chk("midreset_o_data", od, 12'h000);
        rstn = 1'b1;
        edge_cnt = 0; edge_phase = 1'b1;
        for (int i = 0; i < W * H; i++) px(edge_pix(i), 1'b1, 0);
        idle(6);
        edge_phase = 1'b0;
        chk("edge_count_after_reset", 12'(edge_cnt), 12'(2 * (H - 2)));

        // Mode switch at the middle row.
        for (int i = 0; i < W * H; i++) px(edge_pix(i), (i / W) >= H / 2, 0);
        idle(6);

        // Random pixels, modes and gaps.
        npx = 3 * W * H;
        for (int i = 0; i < npx; i++)
            px(12'($urandom), $urandom_range(0, 3) != 0,
               ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);

        idle(10);
        chk("queue_drained", 12'(q.size()), 12'h000);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ps_sobel.md
# ps_sobel

- Streaming 3x3 Sobel edge-detection stage in the 125 MHz processing domain.
- Sits between `ps_preprocess` (upstream) and `mem_interface` (downstream).
- Consumes one 12-bit RGB444 pixel per `i_valid` and produces exactly one 12-bit pixel per accepted input, in order, with fixed latency.
- Uses two internal line buffers to form the 3x3 luma window and emits gradient magnitude as grey RGB444; a mode input selects passthrough.

## Interface
- `IMG_WIDTH`, 640: pixels per line.
- `IMG_HEIGHT`, 480: lines per frame.
- `THRESH`, 32: 7-bit magnitude threshold, used only with `SOBEL_THRESH_EN`.
- `i_clk` in 1: 125 MHz processing clock.
- `i_rstn` in 1: synchronous, active-low reset.
- `i_mode` in 1: 0 = passthrough, 1 = Sobel; sampled per pixel with `i_valid`.
- `i_valid` in 1: input pixel strobe. No backpressure: every strobe is accepted.
- `i_data` in 12: {R[3:0], G[3:0], B[3:0]}.
- `o_valid` out 1: output pixel strobe.
- `o_data` out 12: output pixel.

## Operation
**Position counters**
- `col` (0..IMG_WIDTH-1) and `row` (0..IMG_HEIGHT-1) advance only on `i_valid`.
- `col` wraps to 0 and increments `row`; `row` wraps to 0 after the last line.
- Counters and line buffers update in both modes, so a mode change mid-frame stays coherent.

**Luma**
- `Y = (R + 2G + B) >> 2`, 4 bits, range 0..15.

**Line buffers and window**
- Two IMG_WIDTH x 4-bit line buffers, addressed by `col`, hold rows r-1 and r-2.
- A 3x3 shift window advances one column per accepted pixel. It holds columns c-2..c of rows r-2..r, centred on (r-1, c-1).

**Gradients**
- `gx = (p02 + 2·p12 + p22) − (p00 + 2·p10 + p20)`, signed 7 bits, range ±60.
- `gy` is the same with rows and columns transposed.
- `mag = |gx| + |gy|`, 7 bits, range 0..120.

**Output value**
- Sobel mode: `m = mag >> 3` (0..15); `o_data = {m, m, m}`.
- Border rule: if the accepted pixel had `row < 2` or `col < 2`, `o_data = 12'h000`. Line-buffer contents from before reset are never used.
- Passthrough mode: `o_data` = the input pixel, delayed by the same latency.
- Net effect: the edge map is displaced by (+1, +1). Top two rows and left two columns are 0. Right and bottom edge pixels are not emitted.

**Reset, synchronous and active-low**
- `o_valid = 0`, `o_data = 12'h000`.
- Counters = 0; all pipeline valid bits cleared.
- Line buffer and window contents are not reset.
- Reset asserted mid-frame: in-flight pixels are dropped. The first input after release is treated as (0,0).

## Timing
**Pipeline (3 stages, advance tagged by valid)**
- S1: luma, line-buffer read/write, border flag, mode capture.
- S2: window shift, `gx`/`gy`.
- S3: `mag`, scaling, output mux.

**Latency and ordering**
- `o_valid` is asserted exactly 3 cycles after each accepted `i_valid`.
- Output count equals input count. Order is preserved. Each output carries the mode of its own input.
- Back-to-back `i_valid` gives one pixel per cycle.
- Arbitrary gaps in `i_valid` produce the same `o_data` sequence as continuous input.

**Boundary conditions**
- On line wrap (`col` IMG_WIDTH-1 → 0), the window is not flushed; the border rule masks stale columns.
- On frame wrap, rows 0..1 are masked again.
- Simultaneous `i_valid` and reset: reset wins; the pixel is discarded.

## Configuration
- `SOBEL_THRESH_EN` defined:
  - Sobel-mode output is binary: `o_data = (mag >= THRESH) ? 12'hFFF : 12'h000`.
  - The border rule still forces 12'h000.
- `SOBEL_THRESH_EN` undefined:
  - Output is the scaled magnitude `{m, m, m}`.
  - `THRESH` is unused.
- Passthrough mode and latency are identical in both builds.

## Test plan
1. Flat field, `i_mode = 1`, full frame of 12'h888 → 307200 outputs, all 12'h000, each 3 cycles after its input.
2. Vertical edge, `i_mode = 1`: columns 0..319 = 12'h000, 320..639 = 12'hFFF.
   - Rows ≥ 2 at output columns 320 and 321 → 12'h777 (`mag = 60`); all other outputs 12'h000.
   - With `SOBEL_THRESH_EN` and `THRESH = 32` → 12'hFFF at those positions.
3. Passthrough, `i_mode = 0`, ramp pattern `i_data = index[11:0]` → `o_data` equals the input sequence, delayed exactly 3 cycles.
4. Gapped input: repeat test 2 with `i_valid` high every other cycle → output value sequence identical to test 2; `o_valid` count 307200.
5. Reset mid-frame: deassert `i_rstn` for 1 cycle at pixel (100, 50), then send a full frame of the test 2 pattern.
   - Next cycle `o_valid = 0`.
   - Result matches test 2 exactly; rows 0..1 are zero despite stale line-buffer data.
6. Mode switch at the row-240 boundary, vertical-edge pattern → rows < 240 are passthrough; rows ≥ 240 show 12'h777 at columns 320 and 321 with no corruption at the switch row.
